eb_write_ctrl: RTL
==================

Name: eb_write_ctrl

Overview:
Write-side controller for the RX elastic buffer, clocked in the write domain (read_to_write_clk).
- Accepts decoded symbols and sequences elastic-buffer writes.
- Maintains the binary/Gray write pointer that feeds the pointer synchronizer.
- Computes occupancy from the synchronized Gray read pointer.
- Performs clock compensation by deleting SKP symbols when too full, and handles overflow recovery.

Parameters:
- n, 4: address bits; buffer depth DEPTH = 2^n; pointers are n+1 bits.
- SYM_W, 10: symbol width (data + K flag).
- HIGH_TH, 12: fill level at/above which one SKP per ordered set is deleted.
- RESUME_TH, 8: fill level at/below which the OVERFLOW state exits.

Ports:
- read_to_write_clk  in  1  write-domain clock
- rst_n  in  1  reset, asynchronous, active-low
- sym_valid  in  1  incoming symbol valid
- sym_data  in  SYM_W  incoming symbol
- sym_is_skp  in  1  symbol is SKP (qualified by sym_valid)
- gray_counter_read_sync  in  n+1  read pointer, Gray, already synchronized into this domain
- wr_en  out  1  buffer RAM write strobe
- wr_addr  out  n  RAM write address
- wr_data  out  SYM_W  RAM write data
- gray_counter_write  out  n+1  write pointer, Gray, to the synchronizer
- fill_level  out  n+1  registered occupancy, 0..DEPTH
- full  out  1  fill_level == DEPTH
- skp_deleted  out  1  one-cycle pulse per deleted SKP
- overflow  out  1  sticky overflow flag
- clr_overflow  in  1  synchronous clear of the overflow flag

Behaviour:
- Reset: all outputs 0; internal binary write pointer 0; state RUN.
- Occupancy:
  - occ = wptr_bin − gray2bin(gray_counter_read_sync), modulo 2^(n+1).
  - occ is computed combinationally from current registers.
  - fill_level = occ registered; full = (occ == DEPTH) registered.
- Accepted write, edge k:
  - wr_en = 1, wr_addr = wptr_bin[n−1:0], wr_data = sym_data.
  - wptr_bin increments at the same edge.
- Pointer timing: gray_counter_write = bin2gray(wptr_bin), registered one edge after wr_en (edge k+1), so the RAM write lands before the pointer is visible. Gray changes by exactly one bit per write.
- Wrap-around: pointers wrap naturally at 2^(n+1). occ stays correct across the wrap.
- FSM states: RUN, SKP_HOLD, OVERFLOW.
  - RUN:
    - sym_valid & sym_is_skp & occ >= HIGH_TH → no write, skp_deleted = 1 for one cycle, go to SKP_HOLD.
    - Else sym_valid & occ == DEPTH → no write, overflow set, go to OVERFLOW.
    - Else sym_valid → write.
  - SKP_HOLD:
    - Further SKPs are written normally (maximum one deletion per ordered set).
    - First valid non-SKP symbol is written and returns the FSM to RUN.
    - occ == DEPTH in this state → overflow set, go to OVERFLOW.
  - OVERFLOW:
    - All symbols dropped.
    - Return to RUN when occ <= RESUME_TH. The symbol in that cycle is dropped; writes resume on the next symbol.
- overflow: sticky; cleared by clr_overflow. A simultaneous set and clear → set wins.
- sym_valid = 0: no write, no state change, except the OVERFLOW exit check.
- Reset asserted mid-operation: immediate async clear. Any in-flight write is abandoned; the read side must also be reset.

Optional Feature:
EB_STATS_EN
- Defined: adds outputs skp_del_cnt[15:0] and ovf_cnt[15:0].
  - Saturating counters of skp_deleted pulses and RUN/SKP_HOLD→OVERFLOW entries.
  - Reset to 0; cleared by clr_overflow.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package eb_pkg holds:
  - the state enum (RUN, SKP_HOLD, OVERFLOW);
  - bin2gray/gray2bin functions parameterized on n+1;
  - default threshold constants.
- One sub-module, eb_gray2bin: combinational Gray→binary conversion of the synchronized read pointer. It is reused by the read-side controller.

Test Plan:
1. Reset, then 5 valid symbols, read pointer held at 0.
   → wr_addr 0..4; gray_counter_write sequence 00001, 00011, 00010, 00110, 00111, each one edge after its wr_en; fill_level reaches 5.
2. Fill to 12 with read pointer stalled, then send SKP, SKP, SKP, data.
   → first SKP dropped with skp_deleted pulse; next two SKPs and the data written; fill_level 15; state back to RUN.
3. Fill to 16, then send another symbol.
   → no wr_en; overflow = 1; state OVERFLOW.
   Advance synchronized read pointer to 9 (occ 7).
   → state RUN; next symbol is written.
4. Stream 40 symbols with read pointer following 3 entries behind.
   → correct wrap at 32; fill_level steady at 3; no overflow, no deletion.
5. Assert rst_n low mid-stream.
   → all outputs 0 immediately, state RUN.
   Drive clr_overflow and an overflow event in the same cycle → overflow stays 1.
6. With EB_STATS_EN defined, cause 2 deletions and 1 overflow.
   → skp_del_cnt = 2, ovf_cnt = 1; clr_overflow zeroes both.

Source files
------------

// File: rtl/eb_pkg.sv
// -----------------------------------------------------------------------------
// eb_pkg
// Shared definitions for the RX elastic buffer controllers.
//   - eb_state_t    : write-side FSM states (RUN, SKP_HOLD, OVERFLOW)
//   - bin2gray /
//     gray2bin      : pointer code conversions. They operate on a fixed
//                     EB_PTR_MAX_W-bit container; callers zero-extend their
//                     (n+1)-bit pointer in and truncate the result back. Zero
//                     upper bits do not disturb either conversion, so one pair
//                     of functions serves every pointer width up to 32 bits.
//   - default parameter / threshold constants
// -----------------------------------------------------------------------------
package eb_pkg;

  localparam int EB_N_DEF         = 4;
  localparam int EB_SYM_W_DEF     = 10;
  localparam int EB_HIGH_TH_DEF   = 12;
  localparam int EB_RESUME_TH_DEF = 8;
  localparam int EB_PTR_MAX_W     = 32;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_SKP_HOLD = 2'd1,
    ST_OVERFLOW = 2'd2
  } eb_state_t;

  function automatic logic [EB_PTR_MAX_W-1:0] bin2gray(
    input logic [EB_PTR_MAX_W-1:0] b
  );
    return b ^ (b >> 1);
  endfunction

  function automatic logic [EB_PTR_MAX_W-1:0] gray2bin(
    input logic [EB_PTR_MAX_W-1:0] g
  );
    logic [EB_PTR_MAX_W-1:0] b;
    b[EB_PTR_MAX_W-1] = g[EB_PTR_MAX_W-1];
    for (int i = EB_PTR_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/eb_gray2bin.sv
// -----------------------------------------------------------------------------
// eb_gray2bin
// Combinational Gray -> binary conversion of a pointer that has already been
// synchronized into the local clock domain. Shared by the write- and
// read-side elastic buffer controllers.
// Ports:
//   gray  in  W  Gray-coded pointer
//   bin   out W  binary pointer
// -----------------------------------------------------------------------------
module eb_gray2bin
  import eb_pkg::*;
#(
  parameter int W = EB_N_DEF + 1
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  assign bin = W'(gray2bin(EB_PTR_MAX_W'(gray)));

endmodule

// File: rtl/eb_write_ctrl.sv
// -----------------------------------------------------------------------------
// eb_write_ctrl
// Write-side controller of the RX elastic buffer (read_to_write_clk domain).
// Sequences RAM writes for incoming symbols, owns the write pointer handed to
// the pointer synchronizer, tracks occupancy against the synchronized read
// pointer, deletes one SKP per ordered set when running too full, and drops
// symbols while recovering from an overflow.
//
// Ports:
//   read_to_write_clk       in   write-domain clock
//   rst_n                   in   asynchronous active-low reset
//   sym_valid               in   incoming symbol valid
//   sym_data[SYM_W]         in   incoming symbol (data + K flag)
//   sym_is_skp              in   symbol is a SKP (qualified by sym_valid)
//   gray_counter_read_sync  in   synchronized Gray read pointer (n+1 bits)
//   wr_en                   out  RAM write strobe
//   wr_addr[n]              out  RAM write address
//   wr_data[SYM_W]          out  RAM write data
//   gray_counter_write      out  Gray write pointer to the synchronizer
//   fill_level[n+1]         out  registered occupancy, 0..DEPTH
//   full                    out  registered fill_level == DEPTH
//   skp_deleted             out  one-cycle pulse per deleted SKP
//   overflow                out  sticky overflow flag
//   clr_overflow            in   synchronous clear of overflow
//
// Build option EB_STATS_EN: when defined, adds saturating 16-bit counters
//   skp_del_cnt (deleted SKPs) and ovf_cnt (entries into OVERFLOW), both
//   cleared by reset and by clr_overflow.
// -----------------------------------------------------------------------------
module eb_write_ctrl
  import eb_pkg::*;
#(
  parameter int n         = EB_N_DEF,
  parameter int SYM_W     = EB_SYM_W_DEF,
  parameter int HIGH_TH   = EB_HIGH_TH_DEF,
  parameter int RESUME_TH = EB_RESUME_TH_DEF
) (
  input  logic             read_to_write_clk,
  input  logic             rst_n,
  input  logic             sym_valid,
  input  logic [SYM_W-1:0] sym_data,
  input  logic             sym_is_skp,
  input  logic [n:0]       gray_counter_read_sync,
  output logic             wr_en,
  output logic [n-1:0]     wr_addr,
  output logic [SYM_W-1:0] wr_data,
  output logic [n:0]       gray_counter_write,
  output logic [n:0]       fill_level,
  output logic             full,
  output logic             skp_deleted,
  output logic             overflow,
  input  logic             clr_overflow
`ifdef EB_STATS_EN
  ,
  output logic [15:0]      skp_del_cnt,
  output logic [15:0]      ovf_cnt
`endif
);

  localparam int PTR_W = n + 1;
  localparam int DEPTH = 1 << n;

  localparam logic [PTR_W-1:0] DEPTH_P  = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] HIGH_P   = PTR_W'(HIGH_TH);
  localparam logic [PTR_W-1:0] RESUME_P = PTR_W'(RESUME_TH);

  eb_state_t        state;
  logic [PTR_W-1:0] wptr_bin;
  logic [PTR_W-1:0] rptr_bin;
  logic [PTR_W-1:0] occ;
  logic             del_now;
  logic             ovf_now;
  logic             wr_now;

  eb_gray2bin #(
    .W(PTR_W)
  ) u_rptr_g2b (
    .gray(gray_counter_read_sync),
    .bin (rptr_bin)
  );

  // Modulo-2^(n+1) difference; the extra pointer bit keeps full and empty
  // distinct and makes the subtraction correct across the wrap.
  assign occ = wptr_bin - rptr_bin;

  // Deletion has priority over overflow so a SKP arriving at DEPTH is
  // absorbed rather than tripping recovery. Only RUN may delete, which
  // limits deletion to one SKP per ordered set.
  assign del_now = sym_valid && sym_is_skp && (state == ST_RUN) && (occ >= HIGH_P);
  assign ovf_now = sym_valid && (state != ST_OVERFLOW) && (occ == DEPTH_P) && !del_now;
  assign wr_now  = sym_valid && (state != ST_OVERFLOW) && !del_now && !ovf_now;

  // Single registered stage: all outputs and FSM state update together.
  // The Gray pointer is sampled from the pre-increment register, so it
  // publishes a write one edge after the RAM strobe carrying that write.
  always_ff @(posedge read_to_write_clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= ST_RUN;
      wptr_bin           <= '0;
      wr_en              <= 1'b0;
      wr_addr            <= '0;
      wr_data            <= '0;
      gray_counter_write <= '0;
      fill_level         <= '0;
      full               <= 1'b0;
      skp_deleted        <= 1'b0;
      overflow           <= 1'b0;
    end else begin
      wr_en              <= wr_now;
      skp_deleted        <= del_now;
      gray_counter_write <= PTR_W'(bin2gray(EB_PTR_MAX_W'(wptr_bin)));
      fill_level         <= occ;
      full               <= (occ == DEPTH_P);

      if (wr_now) begin
        wr_addr  <= wptr_bin[n-1:0];
        wr_data  <= sym_data;
        wptr_bin <= wptr_bin + PTR_W'(1);
      end

      // A new overflow event outranks a same-cycle clear.
      if (ovf_now) begin
        overflow <= 1'b1;
      end else if (clr_overflow) begin
        overflow <= 1'b0;
      end

      unique case (state)
        ST_RUN: begin
          if (del_now) begin
            state <= ST_SKP_HOLD;
          end else if (ovf_now) begin
            state <= ST_OVERFLOW;
          end
        end
        ST_SKP_HOLD: begin
          if (ovf_now) begin
            state <= ST_OVERFLOW;
          end else if (wr_now && !sym_is_skp) begin
            state <= ST_RUN;
          end
        end
        ST_OVERFLOW: begin
          // Exit is evaluated every cycle, valid or not; the symbol in the
          // exit cycle is still dropped.
          if (occ <= RESUME_P) begin
            state <= ST_RUN;
          end
        end
        default: begin
          state <= ST_RUN;
        end
      endcase
    end
  end

`ifdef EB_STATS_EN
  // Statistics stage: counts saturate at all-ones; clr_overflow wipes both.
  always_ff @(posedge read_to_write_clk or negedge rst_n) begin
    if (!rst_n) begin
      skp_del_cnt <= '0;
      ovf_cnt     <= '0;
    end else if (clr_overflow) begin
      skp_del_cnt <= '0;
      ovf_cnt     <= '0;
    end else begin
      if (del_now && (skp_del_cnt != 16'hFFFF)) begin
        skp_del_cnt <= skp_del_cnt + 16'd1;
      end
      if (ovf_now && (ovf_cnt != 16'hFFFF)) begin
        ovf_cnt <= ovf_cnt + 16'd1;
      end
    end
  end
`endif

endmodule
